// File: rtl/rf_arb_pkg.sv
//==============================================================================
// Module      : rf_arb_pkg
// Description : Shared constants, buffered-entry type and address decode helper
//               for the register-file write arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rf_arb_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_entry_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_wr_fifo.sv
//==============================================================================
// Module      : rf_wr_fifo
// Description : Circular buffer of muldiv results with address-match kill and
//               exported per-slot valid/address vectors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_wr_fifo
    import rf_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    input  logic                         kill,
    input  logic [ADDR_W-1:0]            kill_addr,
    output rf_entry_t                    head,
    output logic [CNT_W-1:0]             count,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);

    rf_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Kill applies only to entries already stored; a push in the same cycle
    // is younger than the killing write and lands after the kill.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].valid && (mem_q[i].addr == kill_addr)) begin
                    mem_d[i].valid = 1'b0;
                end
            end
        end
        if (pop) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d              = rd_ptr_q + 1'b1;
        end
        if (push) begin
            mem_d[wr_ptr_q] = '{valid: 1'b1, addr: push_addr, data: push_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = mem_q[i].valid;
            entry_addr[i]  = mem_q[i].addr;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
//==============================================================================
// Module      : reg_write_arbiter
// Description : Owns the register-file write port; merges pipeline WB with
//               buffered muldiv results. Optional starvation guard enabled by
//               defining REG_WR_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter int ADDR_W   = rf_arb_pkg::ADDR_W,
    parameter int DATA_W   = rf_arb_pkg::DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_we,
    input  logic [ADDR_W-1:0]             wb_waddr,
    input  logic [DATA_W-1:0]             wb_wd,
    input  logic                          md_valid,
    input  logic [ADDR_W-1:0]             md_waddr,
    input  logic [DATA_W-1:0]             md_wd,
    output logic                          md_ready,
    output logic                          rf_we,
    output logic [ADDR_W-1:0]             rf_waddr,
    output logic [DATA_W-1:0]             rf_wd,
    output logic [rf_arb_pkg::NUM_REGS-1:0] pend_mask,
    output logic                          stall_req
);

    import rf_arb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("reg_write_arbiter: DEPTH must be a power of 2 and >= 2");
    end
    if (ADDR_W != rf_arb_pkg::ADDR_W || DATA_W != rf_arb_pkg::DATA_W) begin : g_bad_width
        $error("reg_write_arbiter: ADDR_W/DATA_W must match rf_arb_pkg");
    end
    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("reg_write_arbiter: MAX_WAIT must be >= 1");
    end

    logic                         wb_hit;
    logic                         md_push;
    logic                         fifo_pop;
    rf_entry_t                    fifo_head;
    logic [CNT_W-1:0]             fifo_count;
    logic [DEPTH-1:0]             entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;

    assign wb_hit   = wb_we && (wb_waddr != '0);
    assign md_ready = (fifo_count < CNT_W'(DEPTH));
    // x0 results still complete the handshake but never occupy a slot.
    assign md_push  = md_valid && md_ready && (md_waddr != '0);
    assign fifo_pop = !wb_hit && (fifo_count != '0);

    rf_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (md_push),
        .push_addr   (md_waddr),
        .push_data   (md_wd),
        .pop         (fifo_pop),
        .kill        (wb_hit),
        .kill_addr   (wb_waddr),
        .head        (fifo_head),
        .count       (fifo_count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wd_d    = rf_wd_q;
        if (wb_hit) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_waddr;
            rf_wd_d    = wb_wd;
        end else if (fifo_pop && fifo_head.valid) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = fifo_head.addr;
            rf_wd_d    = fifo_head.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wd_q    <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wd_q    <= rf_wd_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wd    = rf_wd_q;

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pend_mask = pend_mask | addr_onehot(entry_addr[i]);
            end
        end
        pend_mask[0] = 1'b0;
    end

`ifdef REG_WR_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic              head_valid;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              stall_req_q, stall_req_d;

    assign head_valid = (fifo_count != '0) && fifo_head.valid;

    // Stall rises as the wait count reaches MAX_WAIT and holds until the head leaves.
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        stall_req_d = stall_req_q;
        if (fifo_pop) begin
            wait_cnt_d  = '0;
            stall_req_d = 1'b0;
        end else begin
            if (head_valid && (wait_cnt_q != WAIT_W'(MAX_WAIT))) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (wait_cnt_d == WAIT_W'(MAX_WAIT)) begin
                stall_req_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q  <= '0;
            stall_req_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            stall_req_q <= stall_req_d;
        end
    end

    assign stall_req = stall_req_q;
`else
    assign stall_req = 1'b0;
`endif

endmodule

`default_nettype wire
